dma_rq_read_logic: RTL and testbench

- Requester-request (RQ) side of the DMA read engine: turns a host-read command (address, byte length) into a sequence of single-beat Memory Read request TLPs on the PCIe RQ AXI-Stream.
- Allocates a tag per request and publishes BUSY_TAGS/SIZE_TAGS to the RC completion logic; frees tags on its COMPLETED_TAGS pulses.
- Sits between the descriptor/command engine and the PCIe core RQ interface; 256-bit bus, no straddle.

---
 rtl/dma_rq_read_logic.sv | 249 ++++++++++++++++++++++++
 tb/tb_dma_rq_read_logic.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rq_read_logic.sv
// RQ-side DMA read engine: splits host-read commands into single-beat MemRd TLPs with tag allocation.
// Optional statistics on DEBUG are enabled with `define DMA_RQ_STATS_EN.
module dma_rq_read_logic #(
  parameter int unsigned C_BUS_DATA_WIDTH        = 256,
  parameter int unsigned C_BUS_KEEP_WIDTH        = C_BUS_DATA_WIDTH / 32,
  parameter int unsigned C_WINDOW_SIZE           = 16,
  parameter int unsigned C_LOG2_MAX_READ_REQUEST = 12
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  output logic [C_BUS_DATA_WIDTH-1:0]   M_AXIS_RQ_TDATA,
  output logic [59:0]                   M_AXIS_RQ_TUSER,
  output logic                          M_AXIS_RQ_TLAST,
  output logic [C_BUS_KEEP_WIDTH-1:0]   M_AXIS_RQ_TKEEP,
  output logic                          M_AXIS_RQ_TVALID,
  input  logic                          M_AXIS_RQ_TREADY,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic [63:0]                   CMD_ADDR,
  input  logic [31:0]                   CMD_BYTES,
  input  logic [63:0]                   CURRENT_WINDOW_SIZE,
  output logic [C_WINDOW_SIZE-1:0]      BUSY_TAGS,
  output logic [C_WINDOW_SIZE*11-1:0]   SIZE_TAGS,
  input  logic [C_WINDOW_SIZE-1:0]      COMPLETED_TAGS,
  output logic                          CMD_DONE,
  output logic [63:0]                   DEBUG
);

  localparam int unsigned TAG_W   = (C_WINDOW_SIZE > 1) ? $clog2(C_WINDOW_SIZE) : 1;
  localparam int unsigned WIN_W   = $clog2(C_WINDOW_SIZE + 1);
  localparam int unsigned DW_W    = 11;
  localparam int unsigned MAX_REQ = 1 << C_LOG2_MAX_READ_REQUEST;

  typedef enum logic [1:0] {IDLE, CHUNK, SEND} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          w_cmd_accept;
  logic                          w_issue;
  logic                          w_hs;
  logic                          w_last;

  logic [63:0]                   r_addr;
  logic [31:0]                   r_remaining;
  logic [12:0]                   r_chunk;
  logic [TAG_W-1:0]              r_tag;
  logic [DW_W-1:0]               r_dw_field;
  logic                          r_cmd_ready;
  logic                          r_cmd_done;
  logic [C_BUS_DATA_WIDTH-1:0]   r_tdata;
  logic [59:0]                   r_tuser;
  logic [C_BUS_KEEP_WIDTH-1:0]   r_tkeep;
  logic                          r_tlast;
  logic                          r_tvalid;
  logic [C_WINDOW_SIZE-1:0]      r_busy;
  logic [C_WINDOW_SIZE*11-1:0]   r_size;

  logic [WIN_W-1:0]              w_win_eff;
  logic [C_WINDOW_SIZE-1:0]      w_free;
  logic                          w_found;
  logic [TAG_W-1:0]              w_free_tag;
  logic [12:0]                   w_to_bound;
  logic [31:0]                   w_chunk;
  logic [DW_W-1:0]               w_dw_cnt;
  logic [DW_W-1:0]               w_dw_field;
  logic [3:0]                    w_last_be;
  logic [C_BUS_DATA_WIDTH-1:0]   w_desc;
  logic [C_WINDOW_SIZE-1:0]      w_alloc;

  // Runtime window clamp: 0 behaves as 1, anything above the tag pool is capped.
  always_comb begin
    w_win_eff = WIN_W'(C_WINDOW_SIZE);
    if (CURRENT_WINDOW_SIZE == 64'd0)
      w_win_eff = WIN_W'(1);
    else if (CURRENT_WINDOW_SIZE < 64'(C_WINDOW_SIZE))
      w_win_eff = WIN_W'(CURRENT_WINDOW_SIZE);
  end

  // Lowest free tag inside the effective window (descending scan so the lowest index wins).
  always_comb begin
    w_free     = '0;
    w_found    = 1'b0;
    w_free_tag = '0;
    for (int j = C_WINDOW_SIZE - 1; j >= 0; j--) begin
      w_free[j] = ~r_busy[j] && (WIN_W'(j) < w_win_eff);
      if (w_free[j]) begin
        w_found    = 1'b1;
        w_free_tag = TAG_W'(j);
      end
    end
  end

  // Chunk size never exceeds the max read request nor crosses a 4 KB page.
  always_comb begin
    w_to_bound = 13'd4096 - {1'b0, r_addr[11:0]};
    w_chunk    = r_remaining;
    if (w_chunk > 32'(MAX_REQ))
      w_chunk = 32'(MAX_REQ);
    if (w_chunk > 32'(w_to_bound))
      w_chunk = 32'(w_to_bound);
    w_dw_cnt   = w_chunk[12:2];
    w_dw_field = (w_dw_cnt == 11'd1024) ? 11'd0 : w_dw_cnt;
    w_last_be  = (w_dw_cnt > 11'd1) ? 4'hF : 4'h0;
  end

  always_comb begin
    w_desc          = '0;
    w_desc[63:2]    = r_addr[63:2];
    w_desc[74:64]   = w_dw_field;
    w_desc[78:75]   = 4'b0000;
    w_desc[103:96]  = 8'(w_free_tag);
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_accept = 1'b0;
    w_issue      = 1'b0;
    w_hs         = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (CMD_VALID && r_cmd_ready) begin
          w_cmd_accept = 1'b1;
          w_state_nxt  = CHUNK;
        end
      end
      CHUNK: begin
        if (w_found) begin
          w_issue     = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (M_AXIS_RQ_TREADY) begin
          w_hs = 1'b1;
          if (r_remaining == 32'(r_chunk)) begin
            w_last      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = CHUNK;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_alloc = '0;
    if (w_hs)
      w_alloc = C_WINDOW_SIZE'(1) << r_tag;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_busy      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_cmd_done  <= w_last;
      r_busy      <= (r_busy & ~COMPLETED_TAGS) | w_alloc;
    end
  end

  // Command progress, descriptor register and per-tag size table.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_chunk     <= '0;
      r_tag       <= '0;
      r_dw_field  <= '0;
      r_tdata     <= '0;
      r_tuser     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_size      <= '0;
    end else begin
      if (w_cmd_accept) begin
        r_addr      <= CMD_ADDR;
        r_remaining <= CMD_BYTES;
      end
      if (w_issue) begin
        r_tag      <= w_free_tag;
        r_chunk    <= w_chunk[12:0];
        r_dw_field <= w_dw_field;
        r_tdata    <= w_desc;
        r_tuser    <= {52'd0, w_last_be, 4'hF};
        r_tkeep    <= C_BUS_KEEP_WIDTH'(4'hF);
        r_tlast    <= 1'b1;
        r_tvalid   <= 1'b1;
      end
      if (w_hs) begin
        r_addr      <= r_addr + 64'(r_chunk);
        r_remaining <= r_remaining - 32'(r_chunk);
        r_tdata     <= '0;
        r_tuser     <= '0;
        r_tkeep     <= '0;
        r_tlast     <= 1'b0;
        r_tvalid    <= 1'b0;
        for (int j = 0; j < C_WINDOW_SIZE; j++) begin
          if (r_tag == TAG_W'(j))
            r_size[j*DW_W +: DW_W] <= r_dw_field;
        end
      end
    end
  end

`ifdef DMA_RQ_STATS_EN
  logic [31:0] r_req_cnt;
  logic [31:0] r_stall_cnt;

  // Issued-request and tag-starvation counters, restarted by each new command.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_req_cnt   <= '0;
      r_stall_cnt <= '0;
    end else if (w_cmd_accept) begin
      r_req_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_hs)
        r_req_cnt <= r_req_cnt + 32'd1;
      if ((r_state == CHUNK) && !w_found)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign DEBUG = {r_stall_cnt, r_req_cnt};
`else
  assign DEBUG = '0;
`endif

  assign M_AXIS_RQ_TDATA  = r_tdata;
  assign M_AXIS_RQ_TUSER  = r_tuser;
  assign M_AXIS_RQ_TLAST  = r_tlast;
  assign M_AXIS_RQ_TKEEP  = r_tkeep;
  assign M_AXIS_RQ_TVALID = r_tvalid;
  assign CMD_READY        = r_cmd_ready;
  assign BUSY_TAGS        = r_busy;
  assign SIZE_TAGS        = r_size;
  assign CMD_DONE         = r_cmd_done;

endmodule

// File: tb/tb_dma_rq_read_logic.sv
// Directed bench for dma_rq_read_logic: descriptors, 4 KB splits, tag window, backpressure, reset.
module tb_dma_rq_read_logic;

  localparam int unsigned WS = 16;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [255:0]      M_AXIS_RQ_TDATA;
  logic [59:0]       M_AXIS_RQ_TUSER;
  logic              M_AXIS_RQ_TLAST;
  logic [7:0]        M_AXIS_RQ_TKEEP;
  logic              M_AXIS_RQ_TVALID;
  logic              M_AXIS_RQ_TREADY;
  logic              CMD_VALID;
  logic              CMD_READY;
  logic [63:0]       CMD_ADDR;
  logic [31:0]       CMD_BYTES;
  logic [63:0]       CURRENT_WINDOW_SIZE;
  logic [WS-1:0]     BUSY_TAGS;
  logic [WS*11-1:0]  SIZE_TAGS;
  logic [WS-1:0]     COMPLETED_TAGS;
  logic              CMD_DONE;
  logic [63:0]       DEBUG;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  dma_rq_read_logic #(
    .C_BUS_DATA_WIDTH(256), .C_BUS_KEEP_WIDTH(8),
    .C_WINDOW_SIZE(WS), .C_LOG2_MAX_READ_REQUEST(12)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M_AXIS_RQ_TDATA(M_AXIS_RQ_TDATA), .M_AXIS_RQ_TUSER(M_AXIS_RQ_TUSER),
    .M_AXIS_RQ_TLAST(M_AXIS_RQ_TLAST), .M_AXIS_RQ_TKEEP(M_AXIS_RQ_TKEEP),
    .M_AXIS_RQ_TVALID(M_AXIS_RQ_TVALID), .M_AXIS_RQ_TREADY(M_AXIS_RQ_TREADY),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_ADDR(CMD_ADDR), .CMD_BYTES(CMD_BYTES),
    .CURRENT_WINDOW_SIZE(CURRENT_WINDOW_SIZE),
    .BUSY_TAGS(BUSY_TAGS), .SIZE_TAGS(SIZE_TAGS),
    .COMPLETED_TAGS(COMPLETED_TAGS),
    .CMD_DONE(CMD_DONE), .DEBUG(DEBUG)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (RST_N && CMD_DONE) done_cnt++;

  function automatic logic [255:0] exp_desc(input logic [63:0] a, input logic [10:0] dw,
                                            input logic [7:0] tag);
    logic [255:0] d;
    d          = '0;
    d[63:0]    = {a[63:2], 2'b00};
    d[74:64]   = dw;
    d[103:96]  = tag;
    return d;
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    CMD_VALID = 1'b0; CMD_ADDR = '0; CMD_BYTES = '0;
    COMPLETED_TAGS = '0; M_AXIS_RQ_TREADY = 1'b1;
    CURRENT_WINDOW_SIZE = 64'd16;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [31:0] b);
    int n = 0;
    while (!CMD_READY && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    total++;
    if (CMD_READY !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready_wait got=%b exp=1", CMD_READY);
    end
    CMD_VALID = 1'b1; CMD_ADDR = a; CMD_BYTES = b;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic get_tlp(output logic [255:0] d, output logic [59:0] u, output int cyc);
    cyc = 0;
    do begin
      @(posedge CLK); #1; cyc++;
    end while (!M_AXIS_RQ_TVALID && cyc < 60);
    total++;
    if (M_AXIS_RQ_TVALID !== 1'b1) begin
      bad++;
      $display("FAIL tlp_timeout got tvalid=%b exp=1", M_AXIS_RQ_TVALID);
    end
    d = M_AXIS_RQ_TDATA;
    u = M_AXIS_RQ_TUSER;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; CMD_VALID = 1'b0; COMPLETED_TAGS = '0;
    M_AXIS_RQ_TREADY = 1'b1; CURRENT_WINDOW_SIZE = 64'd16;
    CMD_ADDR = '0; CMD_BYTES = '0;
    repeat (2) @(posedge CLK); #1;
    total++;
    if ({M_AXIS_RQ_TVALID, M_AXIS_RQ_TLAST, CMD_READY, CMD_DONE} !== 4'b0000) begin
      bad++; $display("FAIL rst_ctrl got=%b exp=0000",
                      {M_AXIS_RQ_TVALID, M_AXIS_RQ_TLAST, CMD_READY, CMD_DONE});
    end
    total++;
    if (M_AXIS_RQ_TDATA !== '0 || M_AXIS_RQ_TUSER !== '0 || M_AXIS_RQ_TKEEP !== 8'h00) begin
      bad++; $display("FAIL rst_bus got tdata=%h tuser=%h tkeep=%h exp=0",
                      M_AXIS_RQ_TDATA, M_AXIS_RQ_TUSER, M_AXIS_RQ_TKEEP);
    end
    total++;
    if (BUSY_TAGS !== '0 || SIZE_TAGS !== '0 || DEBUG !== 64'd0) begin
      bad++; $display("FAIL rst_tags got busy=%h size=%h debug=%h exp=0", BUSY_TAGS, SIZE_TAGS, DEBUG);
    end
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (CMD_READY !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b exp=1", CMD_READY);
    end
  endtask

  task automatic test_single();
    logic [255:0] d; logic [59:0] u; int c; int d0;
    do_reset();
    d0 = done_cnt;
    send_cmd(64'h1000, 32'd64);
    get_tlp(d, u, c);
    total++;
    if (d !== exp_desc(64'h1000, 11'd16, 8'd0)) begin
      bad++; $display("FAIL single_desc got=%h exp=%h", d, exp_desc(64'h1000, 11'd16, 8'd0));
    end
    total++;
    if (u !== 60'hFF || M_AXIS_RQ_TKEEP !== 8'h0F || M_AXIS_RQ_TLAST !== 1'b1) begin
      bad++; $display("FAIL single_user got tuser=%h tkeep=%h tlast=%b exp=ff/0f/1",
                      u, M_AXIS_RQ_TKEEP, M_AXIS_RQ_TLAST);
    end
    repeat (2) @(posedge CLK); #1;
    total++;
    if (BUSY_TAGS !== 16'h0001 || SIZE_TAGS[10:0] !== 11'd16) begin
      bad++; $display("FAIL single_tags got busy=%h size0=%0d exp=0001/16", BUSY_TAGS, SIZE_TAGS[10:0]);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL single_done got=%0d exp=1", done_cnt - d0);
    end
  endtask

  task automatic test_4k_cross();
    logic [255:0] d; logic [59:0] u; int c;
    do_reset();
    send_cmd(64'h0FF0, 32'd32);
    get_tlp(d, u, c);
    total++;
    if (d !== exp_desc(64'h0FF0, 11'd4, 8'd0) || u !== 60'hFF) begin
      bad++; $display("FAIL cross_tlp0 got=%h/%h exp=%h/ff", d, u, exp_desc(64'h0FF0, 11'd4, 8'd0));
    end
    get_tlp(d, u, c);
    total++;
    if (d !== exp_desc(64'h1000, 11'd4, 8'd1) || u !== 60'hFF) begin
      bad++; $display("FAIL cross_tlp1 got=%h/%h exp=%h/ff", d, u, exp_desc(64'h1000, 11'd4, 8'd1));
    end
    repeat (2) @(posedge CLK); #1;
    total++;
    if (BUSY_TAGS !== 16'h0003 || SIZE_TAGS[21:0] !== {11'd4, 11'd4}) begin
      bad++; $display("FAIL cross_tags got busy=%h size=%h exp=0003/%h", BUSY_TAGS, SIZE_TAGS[21:0],
                      {11'd4, 11'd4});
    end
  endtask

  task automatic test_max_split();
    logic [255:0] d; logic [59:0] u; int c; int d0;
    do_reset();
    d0 = done_cnt;
    send_cmd(64'h0, 32'd16384);
    for (int i = 0; i < 4; i++) begin
      get_tlp(d, u, c);
      total++;
      if (d !== exp_desc(64'(i) << 12, 11'd0, 8'(i)) || u !== 60'hFF) begin
        bad++; $display("FAIL max_tlp%0d got=%h/%h exp=%h/ff", i, d, u, exp_desc(64'(i) << 12, 11'd0, 8'(i)));
      end
      if (i > 0) begin
        total++;
        if (c != 2) begin
          bad++; $display("FAIL max_rate%0d got=%0d cycles exp=2", i, c);
        end
      end
    end
    repeat (2) @(posedge CLK); #1;
    total++;
    if (BUSY_TAGS !== 16'h000F || SIZE_TAGS[43:0] !== 44'd0 || done_cnt - d0 != 1) begin
      bad++; $display("FAIL max_tags got busy=%h size=%h done=%0d exp=000f/0/1",
                      BUSY_TAGS, SIZE_TAGS[43:0], done_cnt - d0);
    end
  endtask

  task automatic test_window();
    logic [255:0] d; logic [59:0] u; int c; int nz;
    do_reset();
    CURRENT_WINDOW_SIZE = 64'd2;
    send_cmd(64'h0FFC, 32'h1008);
    get_tlp(d, u, c);
    total++;
    if (d !== exp_desc(64'h0FFC, 11'd1, 8'd0) || u !== 60'h0F) begin
      bad++; $display("FAIL win_tlp0 got=%h/%h exp=%h/0f", d, u, exp_desc(64'h0FFC, 11'd1, 8'd0));
    end
    get_tlp(d, u, c);
    total++;
    if (d !== exp_desc(64'h1000, 11'd0, 8'd1) || u !== 60'hFF) begin
      bad++; $display("FAIL win_tlp1 got=%h/%h exp=%h/ff", d, u, exp_desc(64'h1000, 11'd0, 8'd1));
    end
    nz = 0;
    repeat (6) begin
      @(posedge CLK); #1;
      if (M_AXIS_RQ_TVALID !== 1'b0) nz++;
    end
    total++;
    if (nz != 0 || BUSY_TAGS !== 16'h0003) begin
      bad++; $display("FAIL win_stall got valid_cycles=%0d busy=%h exp=0/0003", nz, BUSY_TAGS);
    end
    COMPLETED_TAGS = 16'h0001;
    @(posedge CLK); #1;
    COMPLETED_TAGS = '0;
    total++;
    if (BUSY_TAGS !== 16'h0002) begin
      bad++; $display("FAIL win_free got=%h exp=0002", BUSY_TAGS);
    end
    get_tlp(d, u, c);
    total++;
    if (d !== exp_desc(64'h2000, 11'd1, 8'd0) || u !== 60'h0F || c != 1) begin
      bad++; $display("FAIL win_tlp2 got=%h/%h lat=%0d exp=%h/0f/1", d, u, c, exp_desc(64'h2000, 11'd1, 8'd0));
    end
    repeat (2) @(posedge CLK); #1;
    total++;
`ifdef DMA_RQ_STATS_EN
    if (DEBUG !== {32'd6, 32'd3}) begin
      bad++; $display("FAIL win_debug got=%h exp=%h", DEBUG, {32'd6, 32'd3});
    end
`else
    if (DEBUG !== 64'd0) begin
      bad++; $display("FAIL win_debug got=%h exp=0", DEBUG);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [255:0] d; logic [59:0] u; int c; int diff;
    do_reset();
    M_AXIS_RQ_TREADY = 1'b0;
    send_cmd(64'h3000, 32'd8);
    get_tlp(d, u, c);
    diff = 0;
    repeat (5) begin
      @(posedge CLK); #1;
      if (M_AXIS_RQ_TDATA !== exp_desc(64'h3000, 11'd2, 8'd0) || M_AXIS_RQ_TUSER !== 60'hFF ||
          M_AXIS_RQ_TVALID !== 1'b1 || BUSY_TAGS !== 16'h0000) diff++;
    end
    total++;
    if (diff != 0) begin
      bad++; $display("FAIL bp_hold got bad_cycles=%0d tdata=%h busy=%h exp=0", diff, M_AXIS_RQ_TDATA, BUSY_TAGS);
    end
    M_AXIS_RQ_TREADY = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (BUSY_TAGS !== 16'h0001 || M_AXIS_RQ_TVALID !== 1'b0 || SIZE_TAGS[10:0] !== 11'd2) begin
      bad++; $display("FAIL bp_release got busy=%h valid=%b size0=%0d exp=0001/0/2",
                      BUSY_TAGS, M_AXIS_RQ_TVALID, SIZE_TAGS[10:0]);
    end
  endtask

  task automatic test_reset_in_send();
    logic [255:0] d; logic [59:0] u; int c;
    do_reset();
    send_cmd(64'h0, 32'd16384);
    for (int i = 0; i < 4; i++) get_tlp(d, u, c);
    total++;
    if (BUSY_TAGS !== 16'h0007 || M_AXIS_RQ_TVALID !== 1'b1) begin
      bad++; $display("FAIL rsend_pre got busy=%h valid=%b exp=0007/1", BUSY_TAGS, M_AXIS_RQ_TVALID);
    end
    RST_N = 1'b0;
    #1;
    total++;
    if (M_AXIS_RQ_TVALID !== 1'b0 || M_AXIS_RQ_TDATA !== '0 || M_AXIS_RQ_TUSER !== '0 ||
        M_AXIS_RQ_TKEEP !== 8'h00 || M_AXIS_RQ_TLAST !== 1'b0 || CMD_READY !== 1'b0 ||
        BUSY_TAGS !== '0 || SIZE_TAGS !== '0 || CMD_DONE !== 1'b0 || DEBUG !== 64'd0) begin
      bad++; $display("FAIL rsend_clear got valid=%b busy=%h tdata=%h exp=0/0/0",
                      M_AXIS_RQ_TVALID, BUSY_TAGS, M_AXIS_RQ_TDATA);
    end
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    send_cmd(64'h5000, 32'd4);
    get_tlp(d, u, c);
    total++;
    if (d !== exp_desc(64'h5000, 11'd1, 8'd0) || u !== 60'h0F) begin
      bad++; $display("FAIL rsend_new got=%h/%h exp=%h/0f", d, u, exp_desc(64'h5000, 11'd1, 8'd0));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_4k_cross();
    test_max_split();
    test_window();
    test_backpressure();
    test_reset_in_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
